// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serialises LUT INIT words MSB-first into a LUT config chain, then strobes update.
module lut_cfg_loader #(
  parameter int WIDTH    = 6,
  parameter int NUM_LUTS = 4
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2**WIDTH-1:0]   cfg_data,
  input  logic                  cfg_last,
  output logic                  cfg_sdo,
  output logic                  cfg_sen,
  output logic                  cfg_update,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int D  = 2**WIDTH;
  localparam int BW = $clog2(D) + 1;
  localparam int KW = $clog2(NUM_LUTS + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, UPDATE, DONE, ERR} state_t;
  state_t state, state_n;
  logic [D-1:0]  sreg;
  logic [KW-1:0] k;
  logic [BW-1:0] bcnt;
  logic acc, k_next_full, k_full, bad, last_bit;
  assign cfg_ready  = (state == IDLE) && !R;
  assign cfg_sen    = state == SHIFT;
  assign cfg_sdo    = (state == SHIFT) && sreg[D-1];
  assign cfg_update = state == UPDATE;
  assign busy       = (state == SHIFT) || (state == UPDATE) || ((state == IDLE) && (k != '0));
  assign done       = state == DONE;
  assign err        = state == ERR;
  // Framing is judged against the count this word would make, so a bad word never shifts.
  always_comb begin
    acc         = cfg_valid && cfg_ready;
    k_next_full = (k + KW'(1)) == KW'(NUM_LUTS);
    k_full      = k == KW'(NUM_LUTS);
    bad         = cfg_last != k_next_full;
    last_bit    = bcnt == BW'(D - 1);
    state_n     = state;
    unique case (state)
      IDLE:    state_n = acc ? (bad ? ERR : SHIFT) : IDLE;
      SHIFT:   state_n = last_bit ? (k_full ? UPDATE : IDLE) : SHIFT;
      UPDATE:  state_n = DONE;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
      sreg  <= '0;
      k     <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        sreg <= cfg_data;
        k    <= k + KW'(1);
        bcnt <= '0;
      end else if (state == SHIFT) begin
        sreg <= {sreg[D-2:0], 1'b0};
        bcnt <= bcnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: random/directed loads against a queue-based chain model with a decoupled monitor.
module tb_lut_cfg_loader;
  localparam int W = 6;
  localparam int N = 4;
  localparam int D = 2**W;
  logic C = 0;
  logic R = 1;
  logic cfg_valid = 0;
  logic cfg_last = 0;
  logic [D-1:0] cfg_data = '0;
  logic cfg_ready, cfg_sdo, cfg_sen, cfg_update, busy, done, err;
  lut_cfg_loader #(.WIDTH(W), .NUM_LUTS(N)) dut (
    .C(C), .R(R), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_sdo(cfg_sdo), .cfg_sen(cfg_sen), .cfg_update(cfg_update),
    .busy(busy), .done(done), .err(err)
  );
  always #5 C = ~C;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_acc = 0;
  int last_upd = 0;
  int k_m = 0;
  bit m_err = 0;
  bit m_done = 0;
  bit exp_bits[$];
  int exp_upd_cyc[$];
  always @(posedge C) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: each good word contributes its bits MSB-first to the chain; the final one schedules an update.
  task automatic model_accept(input logic [D-1:0] w, input bit l, output bit bad);
    k_m++;
    bad = l != (k_m == N);
    if (bad) m_err = 1;
    else begin
      for (int i = D - 1; i >= 0; i--) exp_bits.push_back(w[i]);
      if (k_m == N) begin
        m_done = 1;
        exp_upd_cyc.push_back(cyc + D + 1);
      end
    end
  endtask
  always @(negedge C) if (!R) begin
    if (cfg_sen) begin
      if (exp_bits.size() == 0) chk("sen_unexpected", 1, 0);
      else chk("sdo_bit", cfg_sdo, exp_bits.pop_front());
    end else chk("sdo_idle", cfg_sdo, 0);
    if (cfg_update) begin
      last_upd = cyc;
      chk("bits_drained_at_update", exp_bits.size(), 0);
      if (exp_upd_cyc.size() == 0) chk("update_unexpected", 1, 0);
      else chk("update_cycle", cyc, exp_upd_cyc.pop_front());
    end
  end
  task automatic send(input logic [D-1:0] w, input bit l, input int gap, input bit hold);
    int t = 0;
    bit bad;
    repeat (gap) @(negedge C);
    @(negedge C);
    cfg_valid = 1;
    cfg_data = w;
    cfg_last = l;
    #1;
    while (!cfg_ready && t < 200) begin
      @(negedge C);
      #1;
      t++;
    end
    if (!cfg_ready) begin
      chk("accept_timeout", 0, 1);
      cfg_valid = 0;
      return;
    end
    if (k_m == 0) first_acc = cyc;
    model_accept(w, l, bad);
    @(negedge C);
    chk("ready_after_acc", cfg_ready, 0);
    chk("busy_after_acc", busy, !bad);
    chk("err_after_acc", err, bad);
    if (hold) cfg_data = {$urandom, $urandom};
    else cfg_valid = 0;
  endtask
  task automatic finish_load();
    int t = 0;
    while (!(done || err) && t < 500) begin
      @(negedge C);
      t++;
    end
    chk("load_end_done", done, m_done);
    chk("load_end_err", err, m_err);
    repeat (4) begin
      @(negedge C);
      cfg_valid = 1'($urandom);
      cfg_data = {$urandom, $urandom};
      cfg_last = 1'($urandom);
    end
    @(negedge C);
    chk("terminal_ready", cfg_ready, 0);
    chk("terminal_busy", busy, 0);
    chk("terminal_done", done, m_done);
    chk("terminal_err", err, m_err);
    chk("model_drained", exp_bits.size() + exp_upd_cyc.size(), 0);
    cfg_valid = 0;
  endtask
  task automatic do_reset();
    @(negedge C);
    R = 1;
    cfg_valid = 1;
    cfg_last = 0;
    @(posedge C);
    #1;
    exp_bits.delete();
    exp_upd_cyc.delete();
    k_m = 0;
    m_err = 0;
    m_done = 0;
    @(negedge C);
    chk("reset_outs", {cfg_ready, cfg_sdo, cfg_sen, cfg_update, busy, done, err}, 0);
    R = 0;
    cfg_valid = 0;
    #1;
    chk("ready_after_reset", cfg_ready, 1);
    chk("busy_after_reset", busy, 0);
  endtask
  initial begin
    logic [D-1:0] mask;
    bit l;
    bit h;
    mask = 64'hBBF3_5A5A_C3C3_0F00;
    do_reset();
    for (int i = 0; i < N; i++) send(mask, i == N - 1, 0, 0);
    finish_load();
    chk("load_latency", last_upd - first_acc, N * (D + 1));
    do_reset();
    for (int i = 0; i < N; i++) send({$urandom, $urandom}, i == N - 1, 0, 1);
    finish_load();
    do_reset();
    send({$urandom, $urandom}, 0, 0, 0);
    send({$urandom, $urandom}, 1, 0, 0);
    finish_load();
    do_reset();
    for (int i = 0; i < N; i++) send({$urandom, $urandom}, 0, 1, 0);
    finish_load();
    do_reset();
    send({$urandom, $urandom}, 0, 0, 0);
    @(negedge C);
    do_reset();
    for (int i = 0; i < N; i++) send({$urandom, $urandom}, i == N - 1, 0, 0);
    finish_load();
    do_reset();
    repeat (25) begin
      for (int i = 0; i < N && !m_err; i++) begin
        l = i == N - 1;
        if ($urandom_range(0, 7) == 0) l = !l;
        h = $urandom_range(0, 3) == 0;
        send({$urandom, $urandom}, l, $urandom_range(0, 3), h);
      end
      finish_load();
      do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
